regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between NUM_REQ writeback requesters: ALU result, load data and branch-with-link return address. It applies round-robin arbitration with a valid/ready handshake per requester and registers the granted write for one cycle before driving the register file. Writes to the PC index go to a separate PC update port. It sits between the execute/memory writeback sources and the register file write decoder.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/regfile_write_arbiter.sv | 86 ++++++++
 tb/tb_regfile_write_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback requester indices.
// Imported by the write arbiter and by anything that decodes writeback sources.
package regfile_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int PC_ADDR = 15;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_LINK = 2;

    // The PC lives in the register index space but has its own update port.
    function automatic logic is_pc_addr(input logic [ADDR_W-1:0] addr);
        return addr == ADDR_W'(PC_ADDR);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: search starts one past ptr and wraps.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_grant
);

    int cand;

    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any_grant && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
                any_grant   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between writeback requesters with a
// round-robin grant, a one-cycle registered write and PC-index redirection.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      pc_we,
    output logic [DATA_W-1:0]         pc_wdata,
    output logic [IDX_W-1:0]          grant_id,
    output logic [CNT_W-1:0]          write_count
);

    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] win_grant;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (win_grant),
        .idx       (win_idx),
        .any_grant (win_any)
    );

    // Neither a flush nor a reset may hand out a grant.
    assign xfer      = win_any && !flush && !reset;
    assign req_ready = xfer ? win_grant : '0;

    always_comb begin
        sel_addr = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        sel_data = req_data[int'(win_idx)*DATA_W +: DATA_W];
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= IDX_W'(NUM_REQ - 1);
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            pc_we       <= 1'b0;
            pc_wdata    <= '0;
            grant_id    <= '0;
            write_count <= '0;
        end else begin
            rf_we <= 1'b0;
            pc_we <= 1'b0;
            if (xfer) begin
                ptr      <= win_idx;
                grant_id <= win_idx;
                if (is_pc_addr(sel_addr)) begin
                    pc_we    <= 1'b1;
                    pc_wdata <= sel_data;
                end else begin
                    rf_we    <= 1'b1;
                    rf_waddr <= sel_addr;
                    rf_wdata <= sel_data;
                end
            end
            if ((rf_we || pc_we) && write_count != '1)
                write_count <= write_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter: reset, single and
// contended grants, PC redirect, flush, counter saturation and mid-stream reset.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [11:0] req_addr;
    logic [95:0] req_data;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_we;
    logic [31:0] pc_wdata;
    logic [1:0]  grant_id;
    logic [15:0] write_count;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pc_we       (pc_we),
        .pc_wdata    (pc_wdata),
        .grant_id    (grant_id),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
        req_addr[i*4 +: 4]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    // A waiting requester must keep its address and data stable.
    logic [2:0]  pend  = '0;
    logic [11:0] paddr = '0;
    logic [95:0] pdata = '0;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pend[i] && !reset && req_valid[i]) begin
                assert (req_addr[i*4 +: 4] === paddr[i*4 +: 4] &&
                        req_data[i*32 +: 32] === pdata[i*32 +: 32]) else begin
                    bad++;
                    $error("FAIL stable_req%0d: addr/data changed while waiting", i);
                end
            end
        end
        pend  = req_valid & ~req_ready;
        paddr = req_addr;
        pdata = req_data;
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("idle_rf_we",    64'(rf_we),       64'h0);
        check("idle_pc_we",    64'(pc_we),       64'h0);
        check("idle_waddr",    64'(rf_waddr),    64'h0);
        check("idle_wdata",    64'(rf_wdata),    64'h0);
        check("idle_pc_wdata", 64'(pc_wdata),    64'h0);
        check("idle_grant",    64'(grant_id),    64'h0);
        check("idle_count",    64'(write_count), 64'h0);
        check("idle_ready",    64'(req_ready),   64'h0);

        // Single ALU write
        set_req(REQ_ALU, 4'd3, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1 check("single_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        check("single_rf_we", 64'(rf_we),    64'h1);
        check("single_waddr", 64'(rf_waddr), 64'h3);
        check("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        check("single_grant", 64'(grant_id), 64'h0);
        check("single_pc_we", 64'(pc_we),    64'h0);
        tick();
        check("single_done_we",   64'(rf_we),       64'h0);
        check("single_count",     64'(write_count), 64'h1);
        check("single_hold_addr", 64'(rf_waddr),    64'h3);

        // Re-arm the pointer so requester 0 leads the contended burst
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(REQ_ALU,  4'd1, 32'hA1);
        set_req(REQ_LOAD, 4'd2, 32'hA2);
        set_req(REQ_LINK, 4'd4, 32'hA4);
        req_valid = 3'b111;
        #1 check("rr_ready0", 64'(req_ready), 64'b001);
        tick();
        check("rr_waddr0", 64'(rf_waddr), 64'h1);
        check("rr_wdata0", 64'(rf_wdata), 64'hA1);
        check("rr_grant0", 64'(grant_id), 64'h0);
        check("rr_ready1", 64'(req_ready), 64'b010);
        tick();
        check("rr_waddr1", 64'(rf_waddr), 64'h2);
        check("rr_wdata1", 64'(rf_wdata), 64'hA2);
        check("rr_grant1", 64'(grant_id), 64'h1);
        check("rr_ready2", 64'(req_ready), 64'b100);
        tick();
        req_valid = 3'b000;
        check("rr_waddr2", 64'(rf_waddr), 64'h4);
        check("rr_wdata2", 64'(rf_wdata), 64'hA4);
        check("rr_grant2", 64'(grant_id), 64'h2);
        check("rr_rf_we2", 64'(rf_we),    64'h1);
        tick();
        check("rr_idle_we", 64'(rf_we),       64'h0);
        check("rr_count",   64'(write_count), 64'h3);

        // Link write to the PC index goes to the PC port
        set_req(REQ_LINK, 4'd15, 32'h00000100);
        req_valid = 3'b100;
        #1 check("pc_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = 3'b000;
        check("pc_we",       64'(pc_we),    64'h1);
        check("pc_wdata",    64'(pc_wdata), 64'h100);
        check("pc_rf_we",    64'(rf_we),    64'h0);
        check("pc_waddr",    64'(rf_waddr), 64'h4);
        check("pc_wdata_rf", 64'(rf_wdata), 64'hA4);
        check("pc_grant",    64'(grant_id), 64'h2);
        tick();
        check("pc_done", 64'(pc_we),       64'h0);
        check("pc_count", 64'(write_count), 64'h4);

        // Flush blocks grants and leaves the pointer alone
        set_req(REQ_ALU,  4'd5, 32'hB5);
        set_req(REQ_LOAD, 4'd6, 32'hB6);
        req_valid = 3'b011;
        flush     = 1'b1;
        #1 check("flush_ready", 64'(req_ready), 64'b000);
        tick();
        check("flush_rf_we", 64'(rf_we),       64'h0);
        check("flush_pc_we", 64'(pc_we),       64'h0);
        check("flush_count", 64'(write_count), 64'h4);
        flush = 1'b0;
        #1 check("post_flush_ready0", 64'(req_ready), 64'b001);
        tick();
        check("post_flush_waddr0", 64'(rf_waddr), 64'h5);
        check("post_flush_grant0", 64'(grant_id), 64'h0);
        check("post_flush_ready1", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b000;
        flush     = 1'b1;
        // Already-registered write survives a flush in its output cycle
        check("flush_reg_we",    64'(rf_we),    64'h1);
        check("flush_reg_waddr", 64'(rf_waddr), 64'h6);
        check("flush_reg_grant", 64'(grant_id), 64'h1);
        tick();
        flush = 1'b0;
        check("flush_seq_count", 64'(write_count), 64'h6);

        // Back-to-back stream to saturate the counter
        set_req(REQ_ALU, 4'd7, 32'hC7);
        req_valid = 3'b001;
        for (int n = 0; n < 65540; n++) tick();
        check("sat_count", 64'(write_count), 64'hFFFF);
        check("sat_rf_we", 64'(rf_we),       64'h1);
        tick();
        check("sat_no_wrap", 64'(write_count), 64'hFFFF);
        reset = 1'b1;
        #1 check("reset_ready", 64'(req_ready), 64'b000);
        tick();
        reset     = 1'b0;
        req_valid = 3'b000;
        check("reset_count", 64'(write_count), 64'h0);
        check("reset_rf_we", 64'(rf_we),       64'h0);
        check("reset_waddr", 64'(rf_waddr),    64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
